// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and flag bit positions shared by alu, decoder and sequencer
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 0;

    // Unary ops take only operand A, so the sequencer skips the second register read.
    function automatic logic op_is_unary(input logic [2:0] op);
        return (op == OP_NOT) || (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle control FSM running one ALU instruction over the shared data bus
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 3,
    parameter int OP_WIDTH       = 3,
    parameter int FLAGS_WIDTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      out_ready,
    input  logic [OP_WIDTH-1:0]       in_op,
    input  logic [REG_ADDR_WIDTH-1:0] in_dst,
    input  logic [REG_ADDR_WIDTH-1:0] in_src,
    output logic [REG_ADDR_WIDTH-1:0] out_rf_read_addr,
    output logic                      out_rf_enable_out,
    output logic                      out_alu_load_a,
    output logic                      out_alu_load_b,
    output logic [OP_WIDTH-1:0]       out_alu_op,
    output logic                      out_alu_enable_out,
    output logic [REG_ADDR_WIDTH-1:0] out_rf_write_addr,
    output logic                      out_rf_write_en,
    input  logic [FLAGS_WIDTH-1:0]    in_alu_flags,
    output logic [FLAGS_WIDTH-1:0]    out_flags,
    output logic                      out_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ_A = 3'd1,
        S_READ_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [OP_WIDTH-1:0]       op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [REG_ADDR_WIDTH-1:0] src_q, src_d;
    logic [FLAGS_WIDTH-1:0]    flags_q, flags_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            flags_q <= flags_d;
        end
    end

    // Outputs depend only on registered state, never on in_* this cycle.
    always_comb begin
        state_d            = state_q;
        op_d               = op_q;
        dst_d              = dst_q;
        src_d              = src_q;
        flags_d            = flags_q;
        out_ready          = 1'b0;
        out_rf_read_addr   = '0;
        out_rf_enable_out  = 1'b0;
        out_alu_load_a     = 1'b0;
        out_alu_load_b     = 1'b0;
        out_alu_op         = '0;
        out_alu_enable_out = 1'b0;
        out_rf_write_addr  = '0;
        out_rf_write_en    = 1'b0;
        out_done           = 1'b0;

        case (state_q)
            S_IDLE: begin
                out_ready = 1'b1;
                if (in_valid) begin
                    op_d    = in_op;
                    dst_d   = in_dst;
                    src_d   = in_src;
                    state_d = S_READ_A;
                end
            end
            S_READ_A: begin
                out_alu_op        = op_q;
                out_rf_read_addr  = dst_q;
                out_rf_enable_out = 1'b1;
                out_alu_load_a    = 1'b1;
                state_d           = op_is_unary(op_q) ? S_EXEC : S_READ_B;
            end
            S_READ_B: begin
                out_alu_op        = op_q;
                out_rf_read_addr  = src_q;
                out_rf_enable_out = 1'b1;
                out_alu_load_b    = 1'b1;
                state_d           = S_EXEC;
            end
            S_EXEC: begin
                out_alu_op         = op_q;
                out_alu_enable_out = 1'b1;
                state_d            = S_WB;
            end
            S_WB: begin
                // cmp updates flags only; the destination register is left untouched.
                out_alu_op         = op_q;
                out_alu_enable_out = 1'b1;
                out_rf_write_addr  = dst_q;
                out_rf_write_en    = (op_q != OP_CMP);
                out_done           = 1'b1;
                flags_d            = in_alu_flags;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_flags = flags_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control FSM that runs one ALU instruction at a time over the shared 8-bit data bus. It accepts an instruction (op, dst, src) through a valid/ready handshake. It then sequences register-file reads into the ALU operand latches, enables the ALU output, writes the result back and latches the ALU flags. It sits between the instruction decoder and the register file / alu pair.

Parameters:
REG_ADDR_WIDTH, 3, register-file address width (8 registers)
OP_WIDTH, 3, ALU opcode width; encoding shared with alu
FLAGS_WIDTH, 4, flag vector width, ordered {C,N,O,Z} = bits [3:0]

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  instruction present
out_ready  output  1  sequencer can accept an instruction
in_op  input  OP_WIDTH  ALU opcode (add 000, sub 001, or 010, and 011, not 100, cmp 101, shr 110, shl 111)
in_dst  input  REG_ADDR_WIDTH  operand A register and destination
in_src  input  REG_ADDR_WIDTH  operand B register (ignored for not/shr/shl)
out_rf_read_addr  output  REG_ADDR_WIDTH  register-file read address
out_rf_enable_out  output  1  register file drives bus
out_alu_load_a  output  1  ALU latches bus into operand A
out_alu_load_b  output  1  ALU latches bus into operand B
out_alu_op  output  OP_WIDTH  opcode to ALU (held for the whole instruction)
out_alu_enable_out  output  1  ALU drives result on bus
out_rf_write_addr  output  REG_ADDR_WIDTH  register-file write address
out_rf_write_en  output  1  register file captures bus
in_alu_flags  input  FLAGS_WIDTH  flags from ALU
out_flags  output  FLAGS_WIDTH  architectural flags register
out_done  output  1  one-cycle pulse: instruction retired

Behaviour:
- Reset (asynchronous, active-high): state to IDLE, effective immediately on assertion.
  - All control outputs are 0 and out_flags = 0000.
  - Latched op/dst/src are cleared to 0.
  - out_ready = 1 once reset deasserts.
  - Reset mid-instruction aborts the instruction: no write, no flag update, no done.
- States: IDLE, READ_A, READ_B, EXEC, WB.
- IDLE:
  - out_ready = 1.
  - On in_valid & out_ready at a rising edge, latch op/dst/src, then go to READ_A.
  - in_valid while not ready is ignored; it must be held by the sender.
- READ_A: rf_read_addr = dst, rf_enable_out = 1, alu_load_a = 1.
  - Unary ops (not/shr/shl) go to EXEC; all others go to READ_B.
- READ_B: rf_read_addr = src, rf_enable_out = 1, alu_load_b = 1, then go to EXEC.
- EXEC: alu_enable_out = 1; the ALU registers its result and flags at the end of this cycle. Go to WB.
- WB:
  - alu_enable_out stays 1.
  - rf_write_addr = dst; rf_write_en = 1 unless op = cmp.
  - out_flags <= in_alu_flags at the end of WB, for every op.
  - out_done = 1; return to IDLE.
- Latency (accept edge to done pulse): binary ops and cmp 4 cycles; unary ops 3 cycles.
- Throughput: next accept no earlier than the cycle after WB.
- out_alu_op equals the latched op from READ_A through WB.
- Outputs are Moore-decoded from registered state: no combinational path from in_* to any out_*.
- Bus exclusivity invariant: rf_enable_out and alu_enable_out are never both 1. Likewise rf_write_en and rf_enable_out.
- dst == src is legal: the same register is read twice.
- Unknown op values are not possible (3-bit code is fully populated).

Decomposition:
- Shared package alu_pkg holds the opcode localparams (ADD..SHL) and the flag bit indices (FLAG_C = 3, FLAG_N = 2, FLAG_O = 1, FLAG_Z = 0).
- alu and the decoder also use alu_pkg.
- State encoding stays local.
- No sub-module: a single FSM plus instruction and flags registers.

Test Plan:
- Bench wires in the real alu and an 8x8 regfile on a tri-state bus.
- Preload R1 = 0x03, R2 = 0x11; issue add dst = 1, src = 2 -> done 4 cycles after accept; R1 = 0x14; out_flags = 0000.
- R3 = 0x01, R4 = 0x02; sub dst = 3, src = 4 -> R3 = 0xFF; out_flags C = 1, N = 1, O = 0, Z = 0.
- R5 = 0x53, R6 = 0x53; cmp dst = 5, src = 6 -> rf_write_en never asserted; R5 still 0x53; out_flags Z = 1.
- R7 = 0x53; shl dst = 7 -> READ_B skipped; done 3 cycles after accept; R7 = 0xA6.
- Assert reset in EXEC of an add (R1 = 0x40, R2 = 0x41) -> R1 unchanged; out_flags = 0000; no done; out_ready = 1 after deassert.
- Back-to-back: in_valid held high with two instructions -> second accepted the cycle after the first done. Throughout, bus-exclusivity invariant holds and out_ready = 0 while busy.
